// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : sram_arbiter_if
// Brief  : Requester-side and SRAM-controller-side signal bundle of sram_arbiter
// Rev    : 1.0  initial release
// ============================================================================
interface sram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_start_read;
  logic                      mem_start_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_done;
  logic                      busy;
  logic [2:0]                grant_id;

  // Requesters plus SRAM controller: everything around the arbiter
  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata, mem_done,
    input  ack, err, rdata, mem_start_read, mem_start_write,
           mem_addr, mem_wdata, busy, grant_id
  );

  // The arbiter itself
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata, mem_done,
    output ack, err, rdata, mem_start_read, mem_start_write,
           mem_addr, mem_wdata, busy, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sram_arbiter
// Brief  : Shares one asynchronous SRAM word port among NUM_REQ requesters.
//          Define SRAM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
module sram_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 19,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [2:0]        winner;
  logic [7:0]        req_pad;
  logic [7:0]        we_pad;
  logic [ADDR_W-1:0] addr_arr  [8];
  logic [DATA_W-1:0] wdata_arr [8];
  logic [NUM_REQ-1:0] grant_mask;

  // Lanes padded to 8 so a 3-bit index never leaves the array
  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_lane
      if (i < NUM_REQ) begin : g_used
        assign req_pad[i]   = bus.req[i];
        assign we_pad[i]    = bus.req_we[i];
        assign addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
      end else begin : g_pad
        assign req_pad[i]   = 1'b0;
        assign we_pad[i]    = 1'b0;
        assign addr_arr[i]  = '0;
        assign wdata_arr[i] = '0;
      end
    end
    for (i = 0; i < NUM_REQ; i++) begin : g_mask
      assign grant_mask[i] = (bus.grant_id == 3'(i));
    end
  endgenerate

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic [2:0] ptr;
  logic [3:0] probe;

  // Scan offsets high to low so the requester closest to ptr wins last
  always_comb begin
    winner = 3'd0;
    probe  = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      probe = {1'b0, ptr} + 4'(k);
      if (probe >= 4'(NUM_REQ)) probe = probe - 4'(NUM_REQ);
      if (req_pad[probe[2:0]]) winner = probe[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 3'd0;
    end else if (state == IDLE && (|bus.req)) begin
      ptr <= (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
    end
  end
`else
  always_comb begin
    winner = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_pad[3'(k)]) winner = 3'(k);
    end
  end
`endif

  assign bus.busy = (state != IDLE);

  // Pulses are registered on entry to the state in which they are visible
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      lat_we              <= 1'b0;
      bus.ack             <= '0;
      bus.err             <= '0;
      bus.rdata           <= '0;
      bus.mem_start_read  <= 1'b0;
      bus.mem_start_write <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
      bus.grant_id        <= 3'd0;
    end else begin
      bus.ack             <= '0;
      bus.err             <= '0;
      bus.mem_start_read  <= 1'b0;
      bus.mem_start_write <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            lat_we              <= we_pad[winner];
            bus.mem_addr        <= addr_arr[winner];
            bus.mem_wdata       <= wdata_arr[winner];
            bus.grant_id        <= winner;
            bus.mem_start_write <= we_pad[winner];
            bus.mem_start_read  <= ~we_pad[winner];
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_done) begin
            if (!lat_we) bus.rdata <= bus.mem_rdata;
            bus.ack <= grant_mask;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.err <= grant_mask;
            state   <= ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, ABORT: begin
          state <= DRAIN;
        end
        DRAIN: begin
          // A level-type done must fall before the port can be reused
          if (!bus.mem_done) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_arbiter
// Brief  : Directed self-checking bench for sram_arbiter with a timestamp model
// Rev    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 32;
  localparam int TMO     = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // SRAM controller: done for ctl_len cycles starting ctl_delay after a start
  int          ctl_s = -100;
  int          ctl_delay = 1;
  int          ctl_len = 1;
  bit          ctl_never = 1'b1;
  logic [31:0] ctl_rdata = '0;
  assign bus.mem_rdata = ctl_rdata;
  always @(posedge clk) begin
    #2;
    bus.mem_done = !ctl_never && (cyc >= ctl_s + ctl_delay) && (cyc < ctl_s + ctl_delay + ctl_len);
  end

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NUM_REQ; k++) if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
`else
    for (int k = 0; k < NUM_REQ; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  // Model: one transaction described by its start, response and idle cycles
  bit                mvalid = 1'b0, mact = 1'b0, mwe = 1'b0, merr = 1'b0;
  int                g = 0, ts = 0, tr = -1, ti = -1, mptr = 0, mgrant = 0;
  logic [ADDR_W-1:0] maddr = '0;
  logic [DATA_W-1:0] mwdata = '0, mrdata = '0;

  // Event log used by the directed checks
  int                n_rd = 0, n_wr = 0, n_ack = 0, n_err = 0;
  int                last_start = 0, ack_cyc = 0, err_cyc = 0;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata, ack_rdata;
  logic [NUM_REQ-1:0] ack_val, err_val;
  int                grants[$];

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eack, eerr;
    bit estart, ebusy;
    if (mvalid) begin
      estart = mact && (cyc == ts);
      ebusy  = mact && (cyc >= ts) && (ti < 0 || cyc < ti);
      eack   = '0;
      eerr   = '0;
      if (mact && tr == cyc) begin
        if (merr) eerr[g] = 1'b1;
        else      eack[g] = 1'b1;
      end
      check("start_read", bus.mem_start_read, estart && !mwe);
      check("start_write", bus.mem_start_write, estart && mwe);
      check("busy", bus.busy, ebusy);
      check("ack", bus.ack, eack);
      check("err", bus.err, eerr);
      check("grant_id", bus.grant_id, mgrant);
      check("mem_addr", bus.mem_addr, maddr);
      check("mem_wdata", bus.mem_wdata, mwdata);
      check("rdata", bus.rdata, mrdata);
    end

    if (bus.mem_start_read || bus.mem_start_write) begin
      ctl_s      = cyc;
      last_start = cyc;
      st_addr    = bus.mem_addr;
      st_wdata   = bus.mem_wdata;
      if (bus.mem_start_read)  n_rd++;
      if (bus.mem_start_write) n_wr++;
    end
    if (|bus.ack) begin
      n_ack++;
      ack_val   = bus.ack;
      ack_cyc   = cyc;
      ack_rdata = bus.rdata;
      grants.push_back(int'(bus.grant_id));
    end
    if (|bus.err) begin
      n_err++;
      err_val = bus.err;
      err_cyc = cyc;
    end

    if (reset) begin
      mvalid = 1'b1; mact = 1'b0; maddr = '0; mwdata = '0; mrdata = '0;
      mgrant = 0; mptr = 0;
    end else if (mvalid) begin
      if (mact) begin
        if (tr < 0) begin
          if (cyc > ts) begin
            if (bus.mem_done) begin
              tr = cyc + 1; merr = 1'b0;
              if (!mwe) mrdata = bus.mem_rdata;
            end else if (cyc == ts + TMO) begin
              tr = cyc + 1; merr = 1'b1;
            end
          end
        end else if (ti < 0 && cyc > tr && !bus.mem_done) begin
          ti = cyc + 1;
        end
        if (ti >= 0 && cyc + 1 >= ti) mact = 1'b0;
      end else if (|bus.req) begin
        g      = pick(bus.req, mptr);
        mgrant = g;
        mwe    = bus.req_we[g];
        maddr  = bus.req_addr[g*ADDR_W +: ADDR_W];
        mwdata = bus.req_wdata[g*DATA_W +: DATA_W];
        ts = cyc + 1; tr = -1; ti = -1; mact = 1'b1;
        mptr = (g + 1) % NUM_REQ;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_resp(input string name, input int budget);
    int a0 = n_ack;
    int e0 = n_err;
    int k = 0;
    while (n_ack == a0 && n_err == e0 && k < budget) begin
      tick(1);
      k++;
    end
    if (n_ack == a0 && n_err == e0) begin
      checks++;
      errors++;
      $display("FAIL %s no ack/err within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, e0, r0, w0, s1, rq;
    int exp_g;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_grant", bus.grant_id, 3'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_ack", bus.ack, 3'b000);
    tick(1);

    // Contention from reset state
    ctl_never = 1'b0; ctl_delay = 2; ctl_len = 1; ctl_rdata = 32'hA5A50000;
    bus.req_addr = {19'h00003, 19'h00002, 19'h00001};
    grants.delete();
    bus.req = 3'b111;
    for (int t = 0; t < 6; t++) wait_resp("contention_wait", 30);
    bus.req = '0;
    tick(6);
    check("contention_count", grants.size(), 6);
    for (int t = 0; t < 6 && t < grants.size(); t++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_g = t % 3;
`else
      exp_g = 0;
`endif
      check("contention_grant", grants[t], exp_g);
    end

    // Single read; address changes after latching must not matter
    ctl_delay = 3; ctl_rdata = 32'hDEADBEEF;
    r0 = n_rd; w0 = n_wr;
    bus.req_addr[ADDR_W +: ADDR_W] = 19'h00100;
    bus.req_we = '0;
    bus.req = 3'b010;
    tick(3);
    bus.req_addr[ADDR_W +: ADDR_W] = 19'h55555;
    wait_resp("read_wait", 20);
    bus.req = '0;
    tick(4);
    check("read_nrd", n_rd - r0, 1);
    check("read_nwr", n_wr - w0, 0);
    check("read_addr", st_addr, 19'h00100);
    check("read_ackval", ack_val, 3'b010);
    check("read_rdata", ack_rdata, 32'hDEADBEEF);
    check("read_busy", bus.busy, 1'b0);

    // Single write with minimum latency
    ctl_delay = 1;
    w0 = n_wr;
    bus.req_we = 3'b001;
    bus.req_addr[0 +: ADDR_W] = 19'h7FFFF;
    bus.req_wdata[0 +: DATA_W] = 32'h12345678;
    bus.req = 3'b001;
    rq = cyc;
    wait_resp("write_wait", 20);
    bus.req = '0;
    bus.req_wdata[0 +: DATA_W] = 32'hFFFFFFFF;
    tick(4);
    check("write_nwr", n_wr - w0, 1);
    check("write_wdata", st_wdata, 32'h12345678);
    check("write_ackval", ack_val, 3'b001);
    check("write_latency", ack_cyc - rq, 3);
    check("write_rdata_kept", ack_rdata, 32'hDEADBEEF);

    // Timeout then a normal request
    ctl_never = 1'b1;
    a0 = n_ack;
    bus.req_we = '0;
    bus.req = 3'b100;
    wait_resp("timeout_wait", 40);
    check("timeout_errval", err_val, 3'b100);
    check("timeout_delay", err_cyc - last_start, TMO + 1);
    check("timeout_noack", n_ack - a0, 0);
    ctl_never = 1'b0; ctl_delay = 1;
    bus.req = 3'b001;
    wait_resp("after_timeout_wait", 20);
    bus.req = '0;
    check("after_timeout_ack", ack_val, 3'b001);
    tick(4);

    // Level-type done held five cycles, back-to-back request from the same port
    ctl_delay = 2; ctl_len = 5; ctl_rdata = 32'hCAFEF00D;
    a0 = n_ack;
    bus.req = 3'b010;
    wait_resp("level_wait1", 20);
    s1 = last_start;
    wait_resp("level_wait2", 30);
    bus.req = '0;
    check("level_restart_gap", last_start - s1, 9);
    check("level_acks", n_ack - a0, 2);
    check("level_rdata", ack_rdata, 32'hCAFEF00D);
    tick(10);

    // Reset while waiting on the controller
    ctl_never = 1'b1; ctl_len = 1;
    e0 = n_err;
    bus.req = 3'b001;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus.req = '0;
    check("wreset_busy", bus.busy, 1'b0);
    check("wreset_ack", bus.ack, 3'b000);
    check("wreset_err", bus.err, 3'b000);
    check("wreset_start", {bus.mem_start_read, bus.mem_start_write}, 2'b00);
    tick(2);
    ctl_never = 1'b0; ctl_delay = 1;
    bus.req_we = 3'b100;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 19'h00042;
    bus.req_wdata[2*DATA_W +: DATA_W] = 32'h0BADF00D;
    bus.req = 3'b100;
    wait_resp("post_reset_wait", 20);
    bus.req = '0;
    check("post_reset_ack", ack_val, 3'b100);
    check("post_reset_noerr", n_err - e0, 0);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
